// File: rtl/fire_ctrl_fsm.sv
// Supervisory FSM for the fire-fighting controller: confirms a fire, runs pump/valve
// with a minimum run time, cools down, and latches a fault when the tank runs low.
module fire_ctrl_fsm #(
    parameter int CONFIRM_CYC  = 8,
    parameter int PUMP_MIN_CYC = 100,
    parameter int COOLDOWN_CYC = 50,
    parameter int CW           = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SMOKE,
    input  logic       TEMP_HI,
    input  logic       TANK_LOW,
    input  logic       MAN_STOP,
    output logic       ALARM,
    output logic       PUMP,
    output logic       VALVE,
    output logic       FAULT,
    output logic [2:0] STATE
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CONFIRM    = 3'd1,
        EXTINGUISH = 3'd2,
        COOLDOWN   = 3'd3,
        FLT        = 3'd4
    } state_t;

    localparam logic [CW-1:0] CONFIRM_LAST  = CW'(CONFIRM_CYC - 1);
    localparam logic [CW-1:0] PUMP_MIN      = CW'(PUMP_MIN_CYC);
    localparam logic [CW-1:0] COOLDOWN_LAST = CW'(COOLDOWN_CYC - 1);

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic            fire;

    assign fire = SMOKE | TEMP_HI;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (TANK_LOW) begin
                        state_reg <= FLT;
                        cnt_reg   <= '0;
                    end else if (fire && !MAN_STOP) begin
                        // The entering sample already counts as the first confirmation.
                        state_reg <= CONFIRM;
                        cnt_reg   <= CW'(1);
                    end else begin
                        cnt_reg   <= '0;
                    end
                end
                CONFIRM: begin
                    if (TANK_LOW) begin
                        state_reg <= FLT;
                        cnt_reg   <= '0;
                    end else if (MAN_STOP || !fire) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CONFIRM_LAST) begin
                        state_reg <= EXTINGUISH;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg   <= cnt_reg + CW'(1);
                    end
                end
                EXTINGUISH: begin
                    // Dry-run protection beats the minimum run time.
                    if (TANK_LOW) begin
                        state_reg <= FLT;
                        cnt_reg   <= '0;
                    end else if (MAN_STOP || (!fire && cnt_reg >= PUMP_MIN)) begin
                        state_reg <= COOLDOWN;
                        cnt_reg   <= '0;
                    end else if (cnt_reg < PUMP_MIN) begin
                        cnt_reg   <= cnt_reg + CW'(1);
                    end
                end
                COOLDOWN: begin
                    if (TANK_LOW) begin
                        state_reg <= FLT;
                        cnt_reg   <= '0;
                    end else if (fire && !MAN_STOP) begin
                        state_reg <= EXTINGUISH;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == COOLDOWN_LAST) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg   <= cnt_reg + CW'(1);
                    end
                end
                FLT: begin
                    if (!TANK_LOW && MAN_STOP) begin
                        state_reg <= IDLE;
                    end
                    cnt_reg <= '0;
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        ALARM = 1'b0;
        PUMP  = 1'b0;
        VALVE = 1'b0;
        FAULT = 1'b0;
        case (state_reg)
            CONFIRM:    ALARM = 1'b1;
            EXTINGUISH: begin
                ALARM = 1'b1;
                PUMP  = 1'b1;
                VALVE = 1'b1;
            end
            COOLDOWN:   ALARM = 1'b1;
            FLT: begin
                ALARM = 1'b1;
                FAULT = 1'b1;
            end
            default: ;
        endcase
    end

    assign STATE = state_reg;

endmodule
